instr_loader: RTL and testbench

Program loader that writes instruction bytes into the 32-entry instruction memory the processor later fetches from. It accepts a framed byte stream over a valid/ready handshake: a length byte, the instruction bytes, then an optional checksum byte. It drives the memory write port with sequential addresses and reports completion or a framing error. It sits on the memory's write side, clocked by P_clock.

---
 rtl/instr_loader.sv | 163 ++++++++++++++++
 tb/tb_instr_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Program loader for the 2**ADDR_W-entry instruction memory. It takes a framed
// byte stream over a valid/ready handshake: a length byte, then the instruction
// bytes, then (optionally) a checksum byte. It writes the instruction bytes to
// sequential memory addresses starting at 0 and reports done or error.
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, a trailing checksum byte is required and
//                       the load completes only if the 8-bit sum of all
//                       instruction bytes plus the checksum byte is zero.
//                       When undefined, the CSUM state and sum register are
//                       absent and the load completes after the len-th byte.
//
// Ports:
//   P_clock    loader clock, rising edge
//   reset      asynchronous, active-high
//   start      single-cycle pulse; begins or restarts a load
//   in_valid   in_data holds a valid byte
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle (high in LEN, DATA, CSUM)
//   mem_we     registered write strobe, one cycle per instruction byte
//   mem_addr   registered write address
//   mem_wdata  registered write data
//   count      instruction bytes written in the current load
//   busy       high in LEN, DATA, CSUM
//   done       load completed successfully
//   error      load aborted on an illegal length or checksum fault
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              P_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] count_inc;
    logic [ADDR_W:0] len_in;
    logic            len_ok;
    logic            accept;
    logic            last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    // start wins over a byte presented in the same cycle: that byte is dropped.
    assign accept    = in_valid && in_ready && !start;
    assign len_in    = in_data[ADDR_W:0];
    assign len_ok    = (len_in != '0) && (len_in <= MAX_LEN);
    assign count_inc = count + 1'b1;
    assign last_byte = (count_inc == len);

    // Moore status outputs decoded from the state register.
    assign in_ready = (state == S_LEN) || (state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state == S_CSUM)
`endif
                      ;
    assign busy  = in_ready;
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge P_clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_LEN;
        end else if (accept) begin
            case (state)
                S_LEN:  state_next = len_ok ? S_DATA : S_ERR;
                S_DATA: begin
                    if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = S_CSUM;
`else
                        state_next = S_DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: state_next = ((sum + in_data) == '0) ? S_DONE : S_ERR;
`endif
                default: state_next = state;
            endcase
        end
    end

    // Datapath. count doubles as the write pointer: len never exceeds the
    // memory depth, so the pointer cannot wrap and always equals count.
    always_ff @(posedge P_clock or posedge reset) begin
        if (reset) begin
            len       <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                count <= '0;
            end else if (accept) begin
                if (state == S_LEN) begin
                    len   <= len_in;
                    count <= '0;
`ifdef LOADER_CHECKSUM_EN
                    sum   <= '0;
`endif
                end else if (state == S_DATA) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= count[ADDR_W-1:0];
                    mem_wdata <= in_data;
                    count     <= count_inc;
`ifdef LOADER_CHECKSUM_EN
                    sum       <= sum + in_data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. Every accepted data byte pushes its
// expected (address, data) pair onto a scoreboard queue; a monitor pops and
// compares on each mem_we. Inputs are driven and outputs sampled on the
// falling edge of P_clock. Adapts to the LOADER_CHECKSUM_EN build option.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic              P_clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    instr_loader dut (
        .P_clock  (P_clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 P_clock = ~P_clock;
    always @(posedge P_clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every write must match the next expected pair.
    always @(negedge P_clock) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {19'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("write", {19'd0, mem_addr, mem_wdata}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    // Present a byte and return on the falling edge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            @(negedge P_clock);
            waited++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge P_clock);
    endtask

    task automatic send_data(input logic [7:0] b, input int addr);
        exp_q.push_back({5'(addr), b});
        send_byte(b);
    endtask

    task automatic pulse_start(input bit with_byte, input logic [7:0] junk);
        start    = 1'b1;
        in_valid = with_byte;
        in_data  = junk;
        @(negedge P_clock);
        start    = 1'b0;
        in_valid = 1'b0;
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
        check("count_after_start", {26'd0, count}, 32'd0);
        check("flags_after_start", {30'd0, done, error}, 32'd0);
    endtask

    // Length byte, data bytes held back-to-back, optional checksum, result.
    task automatic frame_body(input logic [7:0] d[$], input bit bad_csum);
        logic [7:0] sum = 8'h00;
        int t0;
        send_byte(8'(d.size()));
        t0 = cyc;
        foreach (d[i]) begin
            send_data(d[i], i);
            sum = sum + d[i];
        end
        check("throughput", cyc - t0, d.size());
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum + {7'd0, bad_csum});
        in_valid = 1'b0;
        #1;
        check("done", {31'd0, done}, {31'd0, !bad_csum});
        check("error", {31'd0, error}, {31'd0, bad_csum});
`else
        in_valid = 1'b0;
        #1;
        check("done", {31'd0, done}, 32'd1);
        check("error", {31'd0, error}, 32'd0);
`endif
        check("count", {26'd0, count}, d.size());
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic bad_len(input logic [7:0] l);
        pulse_start(1'b0, 8'h00);
        send_byte(l);
        in_valid = 1'b0;
        check("badlen_error", {31'd0, error}, 32'd1);
        check("badlen_done_busy", {30'd0, done, busy}, 32'd0);
        @(negedge P_clock);
        check("badlen_no_write", {31'd0, mem_we}, 32'd0);
    endtask

    logic [7:0] q[$];
    logic [7:0] q5[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        @(negedge P_clock);
        #1;
        check("reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, error}, 32'd0);
        @(negedge P_clock);
        reset = 1'b0;
        @(negedge P_clock);
        check("idle_outputs", {in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, error}, 32'd0);

        // Nominal frame, good checksum.
        q = '{8'h41, 8'h0A, 8'h80};
        pulse_start(1'b0, 8'h00);
        frame_body(q, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        // Same frame, checksum off by one.
        pulse_start(1'b0, 8'h00);
        frame_body(q, 1'b1);
`endif

        // Illegal lengths, each followed by a good frame that clears error.
        bad_len(8'h00);
        pulse_start(1'b0, 8'h00);
        frame_body(q, 1'b0);
        bad_len(8'h21);
        pulse_start(1'b0, 8'h00);
        frame_body(q, 1'b0);

        // Stall: in_valid goes 1,0,0,1 during DATA.
        pulse_start(1'b0, 8'h00);
        send_byte(8'h03);
        send_data(8'h11, 0);
        in_valid = 1'b0;
        @(negedge P_clock);
        check("stall_no_write0", {31'd0, mem_we}, 32'd0);
        @(negedge P_clock);
        check("stall_no_write1", {31'd0, mem_we}, 32'd0);
        send_data(8'h22, 1);
        send_data(8'h33, 2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - 8'h66);
`endif
        in_valid = 1'b0;
        #1;
        check("stall_done", {30'd0, done, error}, 32'd2);
        check("stall_count", {26'd0, count}, 32'd3);

        // Restart after 2 of 5 data bytes; the byte alongside start is dropped.
        pulse_start(1'b0, 8'h00);
        send_byte(8'h05);
        send_data(8'hA0, 0);
        send_data(8'hA1, 1);
        pulse_start(1'b1, 8'hEE);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_no_write", {31'd0, mem_we}, 32'd0);
        q5 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        frame_body(q5, 1'b0);

        // Reset in the middle of DATA clears all outputs at once.
        pulse_start(1'b0, 8'h00);
        send_byte(8'h04);
        send_data(8'hC0, 0);
        send_data(8'hC1, 1);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_data", {in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, error}, 32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge P_clock);
        reset = 1'b0;
        @(negedge P_clock);

        // Full-depth load: 32 bytes 0x00..0x1F.
        pulse_start(1'b0, 8'h00);
        send_byte(8'h20);
        for (int i = 0; i < 32; i++) send_data(8'(i), i);
        check("last_write", {19'd0, mem_we, mem_addr, mem_wdata}, {19'd0, 1'b1, 5'd31, 8'h1F});
        check("full_count", {26'd0, count}, 32'd32);
`ifdef LOADER_CHECKSUM_EN
        check("full_done_early", {31'd0, done}, 32'd0);
        send_byte(8'h10);
`endif
        in_valid = 1'b0;
        check("full_done", {30'd0, done, error}, 32'd2);
        @(negedge P_clock);
        check("full_scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
